// File: rtl/cpu_configuration.sv
// rtl/cpu_configuration.sv - shared unit encodings, issue control packet and width defaults
package cpu_configuration;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MEM  = 2'd1,
        UNIT_CTRL = 2'd2,
        UNIT_SYS  = 2'd3
    } unit_e;

    localparam logic [2:0] SUB_UPPER = 3'd0;
    localparam logic [2:0] SUB_SPLIT = 3'd1;
    localparam logic [3:0] SEL_NO_UPPER = 4'd3;

    typedef struct packed {
        unit_e      unit;
        logic [2:0] sub_unit;
        logic [3:0] sel;
        logic       imm;
    } iss_ctrl_t;

    // Stores and branches scatter their 12-bit immediate around the rd field.
    function automatic logic is_split_imm(input logic [1:0] unit, input logic [2:0] sub_unit);
        return (sub_unit == SUB_SPLIT) && ((unit == UNIT_INT) || (unit == UNIT_MEM));
    endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - NREG x XLEN register file, one write port, two async read ports
module register_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - operand read, immediate build, scoreboard and registered issue slot
module operand_stage
    import cpu_configuration::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid_i,
    output logic            dec_ready_o,
    input  logic [1:0]      dec_unit_i,
    input  logic [2:0]      dec_sub_unit_i,
    input  logic [3:0]      dec_sel_i,
    input  logic            dec_imm_i,
    input  logic [24:0]     dec_instr_i,
    input  logic [XLEN-1:0] dec_pc_i,
    input  logic [XLEN-1:0] dec_jal_res_i,
    output logic            iss_valid_o,
    input  logic            iss_ready_i,
    output logic [1:0]      iss_unit_o,
    output logic [2:0]      iss_sub_unit_o,
    output logic [3:0]      iss_sel_o,
    output logic            iss_imm_o,
    output logic [XLEN-1:0] iss_rs1_o,
    output logic [XLEN-1:0] iss_rs2_o,
    output logic [XLEN-1:0] iss_immediate_o,
    output logic [XLEN-1:0] iss_jal_res_o,
    output logic [AW-1:0]   iss_rd_o,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i
);

    logic [4:0]      rd_f, rs1_f, rs2_f;
    logic [AW-1:0]   rd_a, rs1_a, rs2_a;
    logic [11:0]     s_imm;
    logic [19:0]     l_imm;
    logic            upper_imm, rs1_v, rs2_v, rd_v;
    logic            byp1, byp2, wb_hits_rd, hazard, slot_free, accept;
    logic [XLEN-1:0] rf_rd1, rf_rd2, op1, op2, imm_val;

    logic            valid_q, valid_d;
    iss_ctrl_t       ctrl_q, ctrl_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, jal_q, jal_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [NREG-1:0] pending_q, pending_d;

    assign rd_f  = dec_instr_i[4:0];
    assign rs1_f = dec_instr_i[12:8];
    assign rs2_f = dec_instr_i[17:13];
    assign rd_a  = rd_f[AW-1:0];
    assign rs1_a = rs1_f[AW-1:0];
    assign rs2_a = rs2_f[AW-1:0];

    assign s_imm = is_split_imm(dec_unit_i, dec_sub_unit_i) ? {dec_instr_i[24:18], dec_instr_i[4:0]}
                                                            : dec_instr_i[24:13];
    assign l_imm = dec_instr_i[24:5];

    assign upper_imm = dec_imm_i && (dec_unit_i == UNIT_INT) && (dec_sub_unit_i == SUB_UPPER)
                       && (dec_sel_i != SEL_NO_UPPER);
    assign rs1_v = !upper_imm;
    assign rs2_v = ((dec_unit_i == UNIT_INT) && (dec_sub_unit_i != SUB_UPPER) && !dec_imm_i)
                 || ((dec_unit_i == UNIT_MEM) && (dec_sub_unit_i == SUB_SPLIT));
    assign rd_v  = ((dec_unit_i == UNIT_INT) || (dec_unit_i == UNIT_MEM))
                 && (dec_sub_unit_i != SUB_SPLIT) && (rd_a != '0);

    always_comb begin
        imm_val = '0;
        if (upper_imm)      imm_val = XLEN'($signed({l_imm, 12'h000}));
        else if (dec_imm_i) imm_val = XLEN'($signed(s_imm));
    end

    register_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_valid_i),
        .waddr_i  (wb_adr_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs1_a),
        .raddr2_i (rs2_a),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

    // A write-back landing this cycle both forwards its data and resolves the hazard.
    assign byp1       = wb_valid_i && (wb_adr_i == rs1_a) && (rs1_a != '0);
    assign byp2       = wb_valid_i && (wb_adr_i == rs2_a) && (rs2_a != '0);
    assign wb_hits_rd = wb_valid_i && (wb_adr_i == rd_a);

    assign op1 = ((dec_unit_i == UNIT_INT) && (dec_sub_unit_i == SUB_UPPER)) ? dec_pc_i
               : (rs1_a == '0) ? '0 : byp1 ? wb_data_i : rf_rd1;
    assign op2 = (rs2_a == '0) ? '0 : byp2 ? wb_data_i : rf_rd2;

    assign hazard = (rs1_v && pending_q[rs1_a] && !byp1)
                  || (rs2_v && pending_q[rs2_a] && !byp2)
                  || (rd_v && pending_q[rd_a] && !wb_hits_rd);

    assign slot_free   = !valid_q || iss_ready_i;
    assign dec_ready_o = slot_free && !hazard && !flush_i;
    assign accept      = dec_valid_i && dec_ready_o;

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        jal_d     = jal_q;
        rd_d      = rd_q;
        pending_d = pending_q;
        if (wb_valid_i) pending_d[wb_adr_i] = 1'b0;
        if (accept) begin
            valid_d         = 1'b1;
            ctrl_d.unit     = unit_e'(dec_unit_i);
            ctrl_d.sub_unit = dec_sub_unit_i;
            ctrl_d.sel      = dec_sel_i;
            ctrl_d.imm      = dec_imm_i;
            rs1_d           = op1;
            rs2_d           = op2;
            imm_d           = imm_val;
            jal_d           = dec_jal_res_i;
            rd_d            = rd_a;
            if (rd_v) pending_d[rd_a] = 1'b1;
        end else if (iss_ready_i || flush_i) begin
            valid_d = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            jal_q     <= '0;
            rd_q      <= '0;
            pending_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            jal_q     <= jal_d;
            rd_q      <= rd_d;
            pending_q <= pending_d;
        end
    end

    assign iss_valid_o     = valid_q;
    assign iss_unit_o      = ctrl_q.unit;
    assign iss_sub_unit_o  = ctrl_q.sub_unit;
    assign iss_sel_o       = ctrl_q.sel;
    assign iss_imm_o       = ctrl_q.imm;
    assign iss_rs1_o       = rs1_q;
    assign iss_rs2_o       = rs2_q;
    assign iss_immediate_o = imm_q;
    assign iss_jal_res_o   = jal_q;
    assign iss_rd_o        = rd_q;

endmodule
